// File: rtl/mem_writeback_stage_pkg.sv
// mem_writeback_stage_pkg: shared LEGv8 widths, the XZR index and the MEM/WB register layout.
package mem_writeback_stage_pkg;
    localparam int WORD  = 64;
    localparam int REG_W = 5;
    localparam int CYCLE = 10;
    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef struct packed {
        logic             valid;
        logic             en;
        logic [REG_W-1:0] rd;
        logic [WORD-1:0]  data;
    } wb_t;
endpackage

// File: rtl/mem_writeback_stage_data_memory.sv
// mem_writeback_stage_data_memory: data array with synchronous write, combinational read and range check.
// DMEM_ERR_EN adds a sticky fault flag for valid out-of-range or misaligned accesses.
module mem_writeback_stage_data_memory
    import mem_writeback_stage_pkg::*;
#(
    parameter int DMEM_WORDS = 64,
    parameter int ADDR_LSB   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [WORD-1:0] addr_i,
    input  logic [WORD-1:0] wdata_i,
    output logic [WORD-1:0] rdata_o
`ifdef DMEM_ERR_EN
    ,
    input  logic            acc_i,
    output logic            err_o
`endif
);
    localparam int IDX_W = $clog2(DMEM_WORDS);

    logic [WORD-1:0]  mem_q [DMEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic             in_range;

    assign idx      = addr_i[ADDR_LSB +: IDX_W];
    assign in_range = (addr_i[WORD-1:ADDR_LSB+IDX_W] == '0) && (addr_i[ADDR_LSB-1:0] == '0);
    // Read sees the pre-edge contents, so a same-cycle store never leaks into the load.
    assign rdata_o  = in_range ? mem_q[idx] : '0;

    always_ff @(posedge clk) begin
        if (!reset && we_i && in_range) mem_q[idx] <= wdata_i;
    end

`ifdef DMEM_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        err_q <= reset ? 1'b0 : (err_q | (acc_i & ~in_range));
    end
    assign err_o = err_q;
`endif
endmodule

// File: rtl/mem_writeback_stage.sv
// mem_writeback_stage: LEGv8 memory access plus MEM/WB register feeding the register-file write port.
// Define DMEM_ERR_EN to expose the sticky dmem_err fault output.
module mem_writeback_stage
    import mem_writeback_stage_pkg::*;
#(
    parameter int DMEM_WORDS = 64,
    parameter int ADDR_LSB   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WORD-1:0]  alu_result,
    input  logic [WORD-1:0]  store_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             reg_write,
    input  logic [REG_W-1:0] dest_reg,
    output logic [WORD-1:0]  write_data,
    output logic [REG_W-1:0] write_reg,
    output logic             reg_write_en,
    output logic             out_valid
`ifdef DMEM_ERR_EN
    ,
    output logic             dmem_err
`endif
);
    logic [WORD-1:0] load_data;
    wb_t             wb_d, wb_q;

    mem_writeback_stage_data_memory #(
        .DMEM_WORDS(DMEM_WORDS),
        .ADDR_LSB  (ADDR_LSB)
    ) u_dmem (
        .clk    (clk),
        .reset  (reset),
        .we_i   (in_valid & mem_write),
        .addr_i (alu_result),
        .wdata_i(store_data),
        .rdata_o(load_data)
`ifdef DMEM_ERR_EN
        ,
        .acc_i  (in_valid & (mem_read | mem_write)),
        .err_o  (dmem_err)
`endif
    );

    always_comb begin
        wb_d.valid = in_valid;
        wb_d.en    = in_valid & reg_write & (dest_reg != XZR);
        wb_d.rd    = dest_reg;
        wb_d.data  = mem_to_reg ? load_data : alu_result;
    end

    always_ff @(posedge clk) begin
        wb_q <= reset ? '0 : wb_d;
    end

    assign write_data   = wb_q.data;
    assign write_reg    = wb_q.rd;
    assign reg_write_en = wb_q.en;
    assign out_valid    = wb_q.valid;
endmodule

// File: doc/mem_writeback_stage.md
Name: mem_writeback_stage

Overview:
- Memory-access plus writeback end of the LEGv8 datapath.
- Consumes the execute-stage result and the decode-stage control bits (mem_read, mem_write, mem_to_reg), and owns the data memory.
- Produces the registered write_data, write_reg and reg_write_en that feed the register-file write port of the decode stage.
- Contains the MEM/WB pipeline register, so results reach the register file exactly one cycle after the access.

Parameters:
- DMEM_WORDS, 64, number of `WORD-wide data-memory entries; must be a power of two.
- ADDR_LSB, 3, byte-to-word shift (8-byte words).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  execute-stage result and controls are valid this cycle.
- alu_result  input  `WORD  ALU output: byte address for loads/stores, or arithmetic result.
- store_data  input  `WORD  register value to store (read_data2 path).
- mem_read  input  1  load request.
- mem_write  input  1  store request.
- mem_to_reg  input  1  1 selects load data for writeback, 0 selects alu_result.
- reg_write  input  1  instruction writes a destination register.
- dest_reg  input  5  destination register number.
- write_data  output  `WORD  value to write to the register file.
- write_reg  output  5  register-file write index.
- reg_write_en  output  1  register-file write strobe.
- out_valid  output  1  writeback slot holds a retired instruction.

Behaviour:
- Reset values: write_data=0, write_reg=0, reg_write_en=0, out_valid=0. Memory contents are not cleared by reset.
- Address decode:
  - word index = alu_result >> ADDR_LSB, truncated to log2(DMEM_WORDS) bits.
  - An access is in range only when all higher address bits are 0 and alu_result[ADDR_LSB-1:0]==0.
- Store: when in_valid & mem_write & in range, mem[index] <= store_data at the edge. Out-of-range or misaligned stores are dropped and memory is unchanged.
- Load: when in_valid & mem_read, the data is captured at the same edge into the MEM/WB register. Latency is 1 cycle, so write_data is valid in the cycle after in_valid.
  - Out-of-range or misaligned load returns 0.
- Same-cycle mem_read & mem_write is illegal from decode. If it occurs, the store wins and the load returns the old memory contents (read-before-write within the cycle).
- Back-to-back store then load to the same index reads the newly stored value. This needs no forwarding logic because the store completes at the earlier edge.
- Writeback register, updated every edge:
  - out_valid <= in_valid.
  - write_data <= mem_to_reg ? load_data : alu_result.
  - write_reg <= dest_reg.
  - reg_write_en <= in_valid & reg_write & (dest_reg != 31). Writes to XZR are suppressed.
- in_valid=0: no memory write occurs, and reg_write_en/out_valid go 0 on the next edge. write_data, write_reg and out_valid still update as listed above; downstream must ignore write_data whenever out_valid=0.
- Reset asserted mid-operation:
  - Any store presented in the same cycle as reset is dropped.
  - The writeback register clears at that edge.
  - Operation resumes on the first edge after reset deasserts.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: adds an output port dmem_err (1 bit, reset 0). It is a sticky flag set at the edge after any valid out-of-range or misaligned load/store, and cleared only by reset.
- Undefined: the port is absent and faults are silently dropped / read as zero as described above.

Decomposition:
- Shared definitions header (`WORD, `CYCLE, XZR index 31, register-index width 5) is reused; the XZR constant is added to it if not already present.
- One natural sub-module: data_memory, holding the array, the synchronous write, the read port and range checking. The writeback mux and pipeline register stay in the top module.

Test Plan:
- Reset: assert reset 2 cycles -> all outputs 0. Then present alu_result=20, reg_write=1, mem_to_reg=0, dest_reg=9 -> next cycle write_data=20, write_reg=9, reg_write_en=1, out_valid=1.
- Store/load: store store_data=30 at alu_result=8. Next cycle, load alu_result=8 with mem_to_reg=1, dest_reg=3 -> write_data=30, write_reg=3 one cycle after the load.
- XZR: alu_result=14, reg_write=1, dest_reg=31 -> out_valid=1, reg_write_en=0.
- Faults:
  - Load alu_result=12 (misaligned) -> write_data=0.
  - Load alu_result=DMEM_WORDS*8 (out of range) -> write_data=0.
  - A prior store at alu_result=DMEM_WORDS*8 leaves entry 0 unchanged.
  - With DMEM_ERR_EN, dmem_err=1 and it stays set.
- Reset mid-store: store 0x55 to address 16 in the same cycle reset=1 -> a later load from address 16 returns the prior contents, not 0x55.
- Bubble: in_valid=0 with mem_write=1, alu_result=0, store_data=7 -> memory entry 0 unchanged, reg_write_en=0, out_valid=0.
